// File: rtl/overlay_cfg_pkg.sv
// Shared types and constants for the overlay configuration loader.
// The readback check (CRC16 helpers) is only used when OVERLAY_CFG_VERIFY_EN is defined.
package overlay_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_VERIFY    = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One bit-serial CRC-16/CCITT step, MSB-first feedback.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/overlay_cfg_loader_crc16.sv
// Bit-serial CRC-16 accumulator used for scan-chain readback checking.
// crc is the registered value; crc_next is what it becomes at the next edge,
// so a caller can compare against the final bit without an extra cycle.
module cfg_crc16
    import overlay_cfg_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc,
    output logic [15:0] crc_next
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC: clear wins over a step; otherwise hold.
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC_INIT;
        end else if (enable) begin
            crc_d = crc16_step(crc_q, bit_in);
        end
    end

    // CRC register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc      = crc_q;
    assign crc_next = crc_d;

endmodule

// File: rtl/overlay_cfg_loader.sv
// Overlay fabric configuration loader: takes host words over valid/ready and
// shifts exactly CHAIN_LEN bits MSB-first onto the fabric scan chain.
// Optional readback check enabled by defining OVERLAY_CFG_VERIFY_EN.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | after reset, nothing loaded; waits for start
// ST_WAIT_WORD | load in progress, shift register empty, host stalled
// ST_SHIFT     | one chain bit per cycle; next word may be taken on last bit
// ST_VERIFY    | chain recirculated once, CRC of returned bits collected
// ST_DONE      | load complete; waits for start
module overlay_cfg_loader
    import overlay_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 400,
    parameter int WORD_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              chain_enable,
    output logic              chain_out,
    input  logic              chain_in,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [WB_W-1:0]  WORD_W_C    = WB_W'(WORD_W);
    localparam logic [WB_W-1:0]  WB_ONE      = WB_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bits_left_q, bits_left_d;
    logic [WB_W-1:0]    wbits_q, wbits_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic               error_q, error_d;

`ifdef OVERLAY_CFG_VERIFY_EN
    logic        crc_clear;
    logic        crc_tx_en;
    logic        crc_rd_en;
    logic [15:0] crc_tx;
    logic [15:0] crc_rd_next;
    logic [15:0] crc_tx_next_unused;
    logic [15:0] crc_rd_unused;
`else
    logic        unused_chain_in;
    assign unused_chain_in = chain_in;
`endif

    // Next-state, counters and chain/handshake outputs.
    always_comb begin
        state_d      = state_q;
        bits_left_d  = bits_left_q;
        wbits_d      = wbits_q;
        shreg_d      = shreg_q;
        error_d      = error_q;
        word_ready   = 1'b0;
        chain_enable = 1'b0;
        chain_out    = 1'b0;
`ifdef OVERLAY_CFG_VERIFY_EN
        crc_clear    = 1'b0;
        crc_tx_en    = 1'b0;
        crc_rd_en    = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_WAIT_WORD;
                    bits_left_d = CHAIN_LEN_C;
                    error_d     = 1'b0;
`ifdef OVERLAY_CFG_VERIFY_EN
                    crc_clear   = 1'b1;
`endif
                end
            end
            ST_WAIT_WORD: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    shreg_d = word_in;
                    wbits_d = WORD_W_C;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                chain_enable = 1'b1;
                chain_out    = shreg_q[WORD_W-1];
                shreg_d      = shreg_q << 1;
                bits_left_d  = bits_left_q - CNT_ONE;
                wbits_d      = wbits_q - WB_ONE;
`ifdef OVERLAY_CFG_VERIFY_EN
                crc_tx_en    = 1'b1;
`endif
                if (bits_left_q == CNT_ONE) begin
                    // Chain full; any low bits still in shreg are discarded.
`ifdef OVERLAY_CFG_VERIFY_EN
                    state_d     = ST_VERIFY;
                    bits_left_d = CHAIN_LEN_C;
`else
                    state_d     = ST_DONE;
`endif
                end else if (wbits_q == WB_ONE) begin
                    // Last bit of this word: take the next one without a bubble.
                    word_ready = 1'b1;
                    if (word_valid) begin
                        shreg_d = word_in;
                        wbits_d = WORD_W_C;
                    end else begin
                        state_d = ST_WAIT_WORD;
                    end
                end
            end
`ifdef OVERLAY_CFG_VERIFY_EN
            ST_VERIFY: begin
                // Recirculate so the fabric ends up holding what was loaded.
                chain_enable = 1'b1;
                chain_out    = chain_in;
                crc_rd_en    = 1'b1;
                bits_left_d  = bits_left_q - CNT_ONE;
                if (bits_left_q == CNT_ONE) begin
                    error_d = (crc_rd_next != crc_tx);
                    state_d = ST_DONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bits_left_q <= '0;
            wbits_q     <= '0;
            shreg_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            wbits_q     <= wbits_d;
            shreg_q     <= shreg_d;
            error_q     <= error_d;
        end
    end

    assign busy  = (state_q == ST_WAIT_WORD) || (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
    assign done  = (state_q == ST_DONE);
    assign error = error_q;

`ifdef OVERLAY_CFG_VERIFY_EN
    cfg_crc16 u_crc_tx (
        .clock    (clock),
        .reset    (reset),
        .clear    (crc_clear),
        .enable   (crc_tx_en),
        .bit_in   (chain_out),
        .crc      (crc_tx),
        .crc_next (crc_tx_next_unused)
    );

    cfg_crc16 u_crc_rd (
        .clock    (clock),
        .reset    (reset),
        .clear    (crc_clear),
        .enable   (crc_rd_en),
        .bit_in   (chain_in),
        .crc      (crc_rd_unused),
        .crc_next (crc_rd_next)
    );
`endif

endmodule
